writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-lane result FIFOs merged onto one registered register-file write port.
// Latency: push on edge T, write visible after edge T+1 (after edge T with WB_ARB_BYPASS_EN defined).
// Backpressure: lane_ready drops when a lane FIFO is full; wb_stall freezes pops, the write port and the RR pointer.
// Optional feature macro: WB_ARB_BYPASS_EN (empty-arbiter single-cycle bypass).

module writeback_arbiter #(
  parameter int         LANES   = 2,
  parameter int         DATA_W  = 32,
  parameter int         ADDR_W  = 7,
  parameter int         DEPTH   = 4,
  parameter logic [4:0] PRIO_OP = 5'd6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         lane_valid,
  input  logic [LANES*5-1:0]       lane_opcode,
  input  logic [LANES*ADDR_W-1:0]  lane_rd,
  input  logic [LANES*DATA_W-1:0]  lane_result,
  input  logic [LANES-1:0]         lane_wren,
  output logic [LANES-1:0]         lane_ready,
  input  logic                     wb_stall,
  output logic                     wb_en,
  output logic [ADDR_W-1:0]        wb_rd,
  output logic [DATA_W-1:0]        wb_data
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int LIDX_W = $clog2(LANES);

  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0]  OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [LIDX_W-1:0] LIDX_ONE = LIDX_W'(1);
  localparam logic [LIDX_W-1:0] LIDX_TOP = LIDX_W'(LANES - 1);

  typedef struct packed {
    logic [4:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef struct packed {
    logic              hit;
    logic              prio;
    logic [LIDX_W-1:0] idx;
  } pick_t;

  // Lowest-index priority requester wins; otherwise first requester at or after start (wrapping).
  function automatic pick_t pick(input logic [LANES-1:0]  req,
                                 input logic [LANES-1:0]  pri,
                                 input logic [LIDX_W-1:0] start);
    pick_t             p;
    logic [LIDX_W:0]   sum;
    logic [LIDX_W-1:0] idx;
    p = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (pri[k]) begin
        p.hit  = 1'b1;
        p.prio = 1'b1;
        p.idx  = LIDX_W'(k);
      end
    end
    if (!p.hit) begin
      for (int k = LANES - 1; k >= 0; k--) begin
        sum = {1'b0, start} + (LIDX_W + 1)'(k);
        if (sum >= (LIDX_W + 1)'(LANES)) begin
          sum = sum - (LIDX_W + 1)'(LANES);
        end
        idx = sum[LIDX_W-1:0];
        if (req[idx]) begin
          p.hit = 1'b1;
          p.idx = idx;
        end
      end
    end
    return p;
  endfunction

  entry_t            mem_q   [LANES][DEPTH];
  logic [PTR_W-1:0]  wptr_q  [LANES];
  logic [PTR_W-1:0]  wptr_d  [LANES];
  logic [PTR_W-1:0]  rptr_q  [LANES];
  logic [PTR_W-1:0]  rptr_d  [LANES];
  logic [OCC_W-1:0]  occ_q   [LANES];
  logic [OCC_W-1:0]  occ_d   [LANES];
  logic [LIDX_W-1:0] rr_q, rr_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  entry_t            in_ent   [LANES];
  entry_t            head     [LANES];
  logic [LANES-1:0]  nonempty;
  logic [LANES-1:0]  head_prio;
  logic [LANES-1:0]  accept;
  logic [LANES-1:0]  push_mask;
  logic [LANES-1:0]  pop_mask;
  pick_t             fifo_pick;
  logic              load;
  entry_t            load_ent;
  logic              rr_upd;
  logic [LIDX_W-1:0] sel_idx;

  // Unpack lane buses, derive FIFO status and the set of requests that will be stored.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      in_ent[i].op   = lane_opcode[i*5 +: 5];
      in_ent[i].rd   = lane_rd[i*ADDR_W +: ADDR_W];
      in_ent[i].data = lane_result[i*DATA_W +: DATA_W];
      head[i]        = mem_q[i][rptr_q[i]];
      nonempty[i]    = (occ_q[i] != '0);
      lane_ready[i]  = (occ_q[i] != OCC_FULL);
      head_prio[i]   = nonempty[i] && (head[i].op == PRIO_OP);
      accept[i]      = lane_valid[i] && lane_ready[i] && lane_wren[i];
    end
  end

  assign fifo_pick = pick(nonempty, head_prio, rr_q);

`ifdef WB_ARB_BYPASS_EN
  logic [LANES-1:0] in_prio;
  pick_t            byp_pick;
  logic             bypass;

  // Candidate for a direct write when every FIFO is empty.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      in_prio[i] = accept[i] && (in_ent[i].op == PRIO_OP);
    end
    byp_pick = pick(accept, in_prio, rr_q);
    bypass   = !wb_stall && (nonempty == '0) && byp_pick.hit;
  end
`endif

  // Grant selection: pop a FIFO head, or (bypass builds) steal an incoming request.
  always_comb begin
    pop_mask  = '0;
    push_mask = accept;
    load      = 1'b0;
    load_ent  = '0;
    rr_upd    = 1'b0;
    sel_idx   = '0;
    if (!wb_stall && fifo_pick.hit) begin
      load                    = 1'b1;
      pop_mask[fifo_pick.idx] = 1'b1;
      load_ent                = head[fifo_pick.idx];
      rr_upd                  = !fifo_pick.prio;
      sel_idx                 = fifo_pick.idx;
    end
`ifdef WB_ARB_BYPASS_EN
    else if (bypass) begin
      load                    = 1'b1;
      push_mask[byp_pick.idx] = 1'b0;
      load_ent                = in_ent[byp_pick.idx];
      rr_upd                  = !byp_pick.prio;
      sel_idx                 = byp_pick.idx;
    end
`endif
  end

  // Next-state for FIFO pointers/occupancy, RR pointer and the write port.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      wptr_d[i] = push_mask[i] ? wptr_q[i] + PTR_ONE : wptr_q[i];
      rptr_d[i] = pop_mask[i]  ? rptr_q[i] + PTR_ONE : rptr_q[i];
      case ({push_mask[i], pop_mask[i]})
        2'b10:   occ_d[i] = occ_q[i] + OCC_ONE;
        2'b01:   occ_d[i] = occ_q[i] - OCC_ONE;
        default: occ_d[i] = occ_q[i];
      endcase
    end
    rr_d = rr_q;
    if (rr_upd) begin
      rr_d = (sel_idx == LIDX_TOP) ? '0 : sel_idx + LIDX_ONE;
    end
    wb_en_d   = wb_en_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (!wb_stall) begin
      wb_en_d = load;
      if (load) begin
        wb_rd_d   = load_ent.rd;
        wb_data_d = load_ent.data;
      end
    end
  end

  // FIFO bookkeeping registers; reset empties every lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        occ_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        occ_q[i]  <= occ_d[i];
      end
    end
  end

  // FIFO storage; contents are don't-care until occupancy marks them valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_mask[i]) begin
        mem_q[i][wptr_q[i]] <= in_ent[i];
      end
    end
  end

  // Round-robin pointer and registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios plus a randomized run against a queue model.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: exercises wb_stall, full FIFOs and refused pushes.

module tb_writeback_arbiter;
  localparam int         LANES  = 2;
  localparam int         DATA_W = 32;
  localparam int         ADDR_W = 7;
  localparam int         DEPTH  = 4;
  localparam logic [4:0] PRIO   = 5'd6;

  logic                    clk;
  logic                    rst;
  logic [LANES-1:0]        lane_valid;
  logic [LANES*5-1:0]      lane_opcode;
  logic [LANES*ADDR_W-1:0] lane_rd;
  logic [LANES*DATA_W-1:0] lane_result;
  logic [LANES-1:0]        lane_wren;
  logic [LANES-1:0]        lane_ready;
  logic                    wb_stall;
  logic                    wb_en;
  logic [ADDR_W-1:0]       wb_rd;
  logic [DATA_W-1:0]       wb_data;

  writeback_arbiter #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PRIO_OP(PRIO)
  ) dut (
    .clk(clk), .rst(rst),
    .lane_valid(lane_valid), .lane_opcode(lane_opcode), .lane_rd(lane_rd),
    .lane_result(lane_result), .lane_wren(lane_wren), .lane_ready(lane_ready),
    .wb_stall(wb_stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  // Reference model: one queue per lane, the lane favoured next by round-robin, and the write port.
  ent_t              mq [LANES][$];
  int                m_rr;
  logic              m_en;
  logic [ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0] m_data;

  int vectors     = 0;
  int miscompares = 0;

  task automatic idle();
    lane_valid  = '0;
    lane_wren   = '0;
    lane_opcode = '0;
    lane_rd     = '0;
    lane_result = '0;
    wb_stall    = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic w, input logic [4:0] op,
                          input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    lane_valid[i]                 = v;
    lane_wren[i]                  = w;
    lane_opcode[i*5 +: 5]         = op;
    lane_rd[i*ADDR_W +: ADDR_W]   = rd;
    lane_result[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LANES; i++) mq[i].delete();
    m_rr   = 0;
    m_en   = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  // Advance the model by one edge using the inputs currently driven, then step the clock.
  task automatic tick();
    logic [LANES-1:0] acc;
    int   g;
    int   byp;
    bit   pr;
    ent_t e;
    g = -1; byp = -1; pr = 0;
    for (int i = 0; i < LANES; i++)
      acc[i] = lane_valid[i] && lane_wren[i] && (mq[i].size() < DEPTH);
    if (!wb_stall) begin
      for (int i = 0; i < LANES; i++)
        if (g < 0 && mq[i].size() > 0)
          if (mq[i][0].op == PRIO) begin g = i; pr = 1; end
      for (int k = 0; k < LANES; k++) begin
        int j;
        j = (m_rr + k) % LANES;
        if (g < 0 && mq[j].size() > 0) g = j;
      end
      if (g >= 0) begin
        e      = mq[g].pop_front();
        m_en   = 1'b1;
        m_rd   = e.rd;
        m_data = e.data;
        if (!pr) m_rr = (g + 1) % LANES;
      end else begin
        m_en = 1'b0;
`ifdef WB_ARB_BYPASS_EN
        for (int i = 0; i < LANES; i++)
          if (byp < 0 && acc[i] && lane_opcode[i*5 +: 5] == PRIO) begin byp = i; pr = 1; end
        for (int k = 0; k < LANES; k++) begin
          int j;
          j = (m_rr + k) % LANES;
          if (byp < 0 && acc[j]) byp = j;
        end
        if (byp >= 0) begin
          m_en   = 1'b1;
          m_rd   = lane_rd[byp*ADDR_W +: ADDR_W];
          m_data = lane_result[byp*DATA_W +: DATA_W];
          if (!pr) m_rr = (byp + 1) % LANES;
        end
`endif
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (acc[i] && i != byp) begin
        e.op   = lane_opcode[i*5 +: 5];
        e.rd   = lane_rd[i*ADDR_W +: ADDR_W];
        e.data = lane_result[i*DATA_W +: DATA_W];
        mq[i].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Put a single lane1 write on the port, waiting a bounded number of edges for it.
  task automatic prime_output(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    set_lane(1, 1'b1, 1'b1, 5'd1, rd, d);
    tick();
    idle();
    while (wb_en !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    vectors++;
    if (wb_en !== 1'b1 || wb_rd !== rd || wb_data !== d) begin
      miscompares++;
      $display("FAIL prime_output: got en=%b rd=%0d data=%h want en=1 rd=%0d data=%h", wb_en, wb_rd, wb_data, rd, d);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    model_clear();
    #3;
    vectors++;
    if (wb_en !== 1'b0) begin miscompares++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
    vectors++;
    if (wb_rd !== '0) begin miscompares++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
    vectors++;
    if (wb_data !== '0) begin miscompares++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    vectors++;
    if (lane_ready !== 2'b11) begin miscompares++; $display("FAIL reset_lane_ready: got %b want 11", lane_ready); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single_push();
    do_reset();
    set_lane(0, 1'b1, 1'b1, 5'd1, 7'd5, 32'hDEADBEEF);
    tick();
    idle();
`ifndef WB_ARB_BYPASS_EN
    vectors++;
    if (wb_en !== 1'b0) begin miscompares++; $display("FAIL single_early: got en=%b want 0", wb_en); end
    tick();
`endif
    vectors++;
    if (wb_en !== 1'b1 || wb_rd !== 7'd5 || wb_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_write: got en=%b rd=%0d data=%h want en=1 rd=5 data=deadbeef", wb_en, wb_rd, wb_data);
    end
    tick();
    vectors++;
    if (wb_en !== 1'b0) begin miscompares++; $display("FAIL single_after: got en=%b want 0", wb_en); end
  endtask

  task automatic test_priority();
    do_reset();
    wb_stall = 1'b1;
    set_lane(0, 1'b1, 1'b1, 5'd2, 7'd20, 32'hA0A0_0000);
    set_lane(1, 1'b1, 1'b1, 5'd6, 7'd21, 32'hB1B1_0000);
    tick();
    idle();
    tick();
    vectors++;
    if (wb_en !== 1'b1 || wb_rd !== 7'd21 || wb_data !== 32'hB1B1_0000) begin
      miscompares++;
      $display("FAIL prio_first: got en=%b rd=%0d data=%h want en=1 rd=21 data=b1b10000", wb_en, wb_rd, wb_data);
    end
    tick();
    vectors++;
    if (wb_en !== 1'b1 || wb_rd !== 7'd20 || wb_data !== 32'hA0A0_0000) begin
      miscompares++;
      $display("FAIL prio_second: got en=%b rd=%0d data=%h want en=1 rd=20 data=a0a00000", wb_en, wb_rd, wb_data);
    end
    tick();
    vectors++;
    if (wb_en !== 1'b0) begin miscompares++; $display("FAIL prio_drained: got en=%b want 0", wb_en); end
  endtask

  task automatic test_round_robin();
    logic [ADDR_W-1:0] exp_rd;
    logic [DATA_W-1:0] exp_data;
    do_reset();
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 1'b1, 1'b1, 5'd1, ADDR_W'(k),     32'h1000_0000 + DATA_W'(k));
      set_lane(1, 1'b1, 1'b1, 5'd1, ADDR_W'(8 + k), 32'h2000_0000 + DATA_W'(k));
      tick();
    end
    idle();
    for (int n = 0; n < 6; n++) begin
      tick();
      exp_rd   = ADDR_W'((n % 2) * 8 + n / 2);
      exp_data = ((n % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000) + DATA_W'(n / 2);
      vectors++;
      if (wb_en !== 1'b1 || wb_rd !== exp_rd || wb_data !== exp_data) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got en=%b rd=%0d data=%h want en=1 rd=%0d data=%h", n, wb_en, wb_rd, wb_data, exp_rd, exp_data);
      end
    end
    tick();
    vectors++;
    if (wb_en !== 1'b0) begin miscompares++; $display("FAIL rr_drained: got en=%b want 0", wb_en); end
  endtask

  task automatic test_full_stall();
    do_reset();
    prime_output(7'd33, 32'hCAFE_0001);
    wb_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        vectors++;
        if (lane_ready !== 2'b10) begin miscompares++; $display("FAIL full_ready: got %b want 10", lane_ready); end
      end
      set_lane(0, 1'b1, 1'b1, 5'd1, ADDR_W'(40 + k), 32'hF000_0000 + DATA_W'(k));
      tick();
      vectors++;
      if (wb_en !== 1'b1 || wb_rd !== 7'd33 || wb_data !== 32'hCAFE_0001) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got en=%b rd=%0d data=%h want en=1 rd=33 data=cafe0001", k, wb_en, wb_rd, wb_data);
      end
    end
    vectors++;
    if (lane_ready[0] !== 1'b0) begin miscompares++; $display("FAIL full_refused_ready: got %b want 0", lane_ready[0]); end
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (wb_en !== 1'b1 || wb_rd !== ADDR_W'(40 + k) || wb_data !== 32'hF000_0000 + DATA_W'(k)) begin
        miscompares++;
        $display("FAIL full_drain[%0d]: got en=%b rd=%0d data=%h want en=1 rd=%0d", k, wb_en, wb_rd, wb_data, 40 + k);
      end
    end
    tick();
    vectors++;
    if (wb_en !== 1'b0) begin miscompares++; $display("FAIL full_fifth_dropped: got en=%b want 0", wb_en); end
  endtask

  task automatic test_wren_drop();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_lane(0, 1'b1, 1'b0, 5'd1, 7'd50, 32'hBAD0_0000);
      tick();
      vectors++;
      if (wb_en !== 1'b0 || lane_ready !== 2'b11) begin
        miscompares++;
        $display("FAIL drop_live[%0d]: got en=%b ready=%b want en=0 ready=11", k, wb_en, lane_ready);
      end
    end
    wb_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_lane(0, 1'b1, 1'b0, 5'd1, 7'd51, 32'hBAD0_0001);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      set_lane(0, 1'b1, 1'b1, 5'd1, ADDR_W'(60 + k), 32'h0000_0600 + DATA_W'(k));
      tick();
      vectors++;
      if (lane_ready[0] !== (k < 3)) begin
        miscompares++;
        $display("FAIL drop_occupancy[%0d]: got ready=%b want %b", k, lane_ready[0], (k < 3));
      end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (wb_en !== 1'b1 || wb_rd !== ADDR_W'(60 + k) || wb_data !== 32'h0000_0600 + DATA_W'(k)) begin
        miscompares++;
        $display("FAIL drop_drain[%0d]: got en=%b rd=%0d data=%h want rd=%0d", k, wb_en, wb_rd, wb_data, 60 + k);
      end
    end
    tick();
    vectors++;
    if (wb_en !== 1'b0) begin miscompares++; $display("FAIL drop_drained: got en=%b want 0", wb_en); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    prime_output(7'd77, 32'h7777_7777);
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_lane(0, 1'b1, 1'b1, 5'd1, ADDR_W'(90 + k), 32'h9000_0000 + DATA_W'(k));
      set_lane(1, 1'b1, 1'b1, 5'd6, ADDR_W'(95 + k), 32'h9500_0000 + DATA_W'(k));
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (wb_en !== 1'b0 || wb_rd !== '0 || wb_data !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got en=%b rd=%0d data=%h want all zero", wb_en, wb_rd, wb_data);
    end
    vectors++;
    if (lane_ready !== 2'b11) begin miscompares++; $display("FAIL midreset_ready: got %b want 11", lane_ready); end
    idle();
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if (wb_en !== 1'b0) begin miscompares++; $display("FAIL midreset_quiet[%0d]: got en=%b want 0", k, wb_en); end
    end
  endtask

  task automatic test_random();
    logic [LANES-1:0] exp_rdy;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < LANES; i++) begin
        set_lane(i,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) != 0,
                 ($urandom_range(0, 3) == 0) ? PRIO : 5'($urandom_range(0, 31)),
                 ADDR_W'($urandom_range(0, 127)),
                 DATA_W'($urandom));
      end
      wb_stall = ($urandom_range(0, 99) < ((n % 100 < 50) ? 60 : 10));
      tick();
      vectors++;
      if (wb_en !== m_en || (m_en && (wb_rd !== m_rd || wb_data !== m_data))) begin
        miscompares++;
        $display("FAIL random_write[%0d]: got en=%b rd=%0d data=%h want en=%b rd=%0d data=%h", n, wb_en, wb_rd, wb_data, m_en, m_rd, m_data);
      end
      for (int i = 0; i < LANES; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
      vectors++;
      if (lane_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL random_ready[%0d]: got %b want %b", n, lane_ready, exp_rdy);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_single_push();
    test_priority();
    test_round_robin();
    test_full_stall();
    test_wren_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
